// File: rtl/gelato_warp_scheduler.sv
// Warp scheduler: consumer side of the per-warp instruction buffers.
// Each cycle it picks at most one eligible warp, pulses that warp's caught bit
// to pop its buffer tail, and registers the instruction into a single-entry
// issue stage.
// Optional feature macro: GELATO_WARPSKD_GREEDY_EN (greedy-then-round-robin).
// When it is undefined the scheduler is strict round-robin.
module gelato_warp_scheduler #(
  parameter int unsigned WARP_NUM = 8,
  parameter int unsigned INST_W   = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 rdy,
  input  logic [WARP_NUM-1:0]                  buf_valid,
  input  logic [WARP_NUM*INST_W-1:0]           buf_inst,
  output logic [WARP_NUM-1:0]                  buf_caught,
  input  logic [WARP_NUM-1:0]                  warp_active,
  input  logic [WARP_NUM-1:0]                  warp_stall,
  output logic                                 issue_valid,
  input  logic                                 issue_ready,
  output logic [INST_W-1:0]                    issue_inst,
  output logic [$clog2(WARP_NUM)-1:0]          issue_warp
);

  localparam int unsigned WID_W = $clog2(WARP_NUM);

  typedef enum logic {StEmpty, StFull} issue_state_e;

  issue_state_e      state_q;
  logic [WID_W-1:0]  scan_base_q;  // rr_ptr, or last_warp in greedy mode
  logic [INST_W-1:0] issue_inst_q;
  logic [WID_W-1:0]  issue_warp_q;

  logic [WARP_NUM-1:0] elig;
  logic                slot_free;
  logic                sel_valid;
  logic [WID_W-1:0]    sel;
  logic [WID_W-1:0]    idx;
  logic [INST_W-1:0]   sel_inst;
  logic [WID_W-1:0]    next_base;

  assign elig        = buf_valid & warp_active & ~warp_stall;
  assign issue_valid = (state_q == StFull);
  assign issue_inst  = issue_inst_q;
  assign issue_warp  = issue_warp_q;
  // A full slot can be drained and refilled on the same edge.
  assign slot_free   = ~issue_valid | issue_ready;

  // Pick the first eligible warp scanning upward from the scan base, with wrap.
  always_comb begin
    sel_valid = 1'b0;
    sel       = '0;
    idx       = '0;
    if (rdy && slot_free) begin
      for (int k = 0; k < WARP_NUM; k++) begin
        idx = scan_base_q + WID_W'(k);
        if (!sel_valid && elig[idx]) begin
          sel_valid = 1'b1;
          sel       = idx;
        end
      end
    end
  end

  // Mux the selected tail instruction and decode the one-hot pop pulse.
  always_comb begin
    sel_inst   = '0;
    buf_caught = '0;
    for (int i = 0; i < WARP_NUM; i++) begin
      if (sel == WID_W'(i)) begin
        sel_inst      = buf_inst[i*INST_W +: INST_W];
        buf_caught[i] = sel_valid;
      end
    end
  end

`ifdef GELATO_WARPSKD_GREEDY_EN
  // Greedy: restart the scan at the warp just selected so it keeps issuing.
  assign next_base = sel;
`else
  // Round-robin: restart the scan just past the warp just selected.
  assign next_base = sel + WID_W'(1);
`endif

  // Issue-register FSM plus scan base; rdy=0 freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      scan_base_q  <= '0;
      issue_inst_q <= '0;
      issue_warp_q <= '0;
    end else if (rdy) begin
      if (sel_valid) begin
        state_q      <= StFull;
        scan_base_q  <= next_base;
        issue_inst_q <= sel_inst;
        issue_warp_q <= sel;
      end else if (state_q == StFull && issue_ready) begin
        state_q <= StEmpty;
      end
    end
  end

endmodule
